// File: rtl/packet_switch_allocator_pkg.sv
// Shared types for the crossbar switch allocator: requester-select and outport codes.
package packet_switch_allocator_pkg;

    localparam int unsigned ALLOC_NUM_IN       = 8;
    localparam int unsigned ALLOC_NUM_OUT      = 4;
    localparam int unsigned ALLOC_LOCK_TIMEOUT = 16;

    localparam int unsigned ALLOC_SEL_W = $clog2(ALLOC_NUM_IN);
    localparam int unsigned ALLOC_OUT_W = $clog2(ALLOC_NUM_OUT);

    typedef logic [ALLOC_SEL_W-1:0] alloc_sel_t;
    typedef logic [ALLOC_OUT_W-1:0] outport_t;

endpackage

// File: rtl/packet_switch_allocator_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, with wrap-around.
module rr_pick #(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int unsigned pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!valid && req[IDX_W'(pos)]) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/packet_switch_allocator.sv
// Crossbar switch allocator: per-outport round-robin grant with head-to-tail packet locking,
// credit gating and a lock-stall timeout that force-releases a stuck owner.
module packet_switch_allocator
    import packet_switch_allocator_pkg::*;
#(
    parameter  int unsigned NUM_IN       = ALLOC_NUM_IN,
    parameter  int unsigned NUM_OUT      = ALLOC_NUM_OUT,
    parameter  int unsigned LOCK_TIMEOUT = ALLOC_LOCK_TIMEOUT,
    localparam int unsigned SEL_W        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int unsigned OUT_W        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int unsigned CNT_W        = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_IN-1:0]                req_valid,
    input  logic [NUM_IN-1:0][OUT_W-1:0]     req_outport,
    input  logic [NUM_IN-1:0]                req_tail,
    input  logic [NUM_OUT-1:0]               credit_ok,
    output logic [NUM_IN-1:0]                grant,
    output logic [NUM_OUT-1:0]               enable,
    output logic [NUM_OUT-1:0][SEL_W-1:0]    select,
    output logic [NUM_OUT-1:0]               locked,
    output logic                             timeout_err
);

    logic [NUM_OUT-1:0][SEL_W-1:0]  owner_q;
    logic [NUM_OUT-1:0][SEL_W-1:0]  ptr_q;
    logic [NUM_OUT-1:0][CNT_W-1:0]  cnt_q;

    logic [NUM_IN-1:0]              owns_lock;
    logic [NUM_OUT-1:0][NUM_IN-1:0] cand;
    logic [NUM_OUT-1:0]             pick_valid;
    logic [NUM_OUT-1:0][SEL_W-1:0]  pick_idx;
    logic [NUM_OUT-1:0]             fire;
    logic [NUM_OUT-1:0]             force_rel;

    function automatic logic [SEL_W-1:0] inc_idx(input logic [SEL_W-1:0] x);
        return (x == SEL_W'(NUM_IN - 1)) ? '0 : x + SEL_W'(1);
    endfunction

    // An input that owns a locked outport may not win any other outport.
    always_comb begin
        owns_lock = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                if (locked[j] && (owner_q[j] == SEL_W'(i))) begin
                    owns_lock[i] = 1'b1;
                end
            end
        end
    end

    // Locked outports see only their owner; unlocked ones see every free requester.
    always_comb begin
        cand = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (req_valid[i] && (req_outport[i] == OUT_W'(j))) begin
                    if (locked[j]) begin
                        cand[j][i] = (owner_q[j] == SEL_W'(i));
                    end else begin
                        cand[j][i] = !owns_lock[i];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_pick
        rr_pick #(.N(NUM_IN)) u_rr_pick (
            .req   (cand[g]),
            .ptr   (ptr_q[g]),
            .valid (pick_valid[g]),
            .idx   (pick_idx[g])
        );
    end

    // Grant fan-out; everything is forced low while reset is held.
    always_comb begin
        grant     = '0;
        enable    = '0;
        select    = '0;
        fire      = '0;
        force_rel = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            fire[j] = pick_valid[j] && credit_ok[j] && !rst;
            if (fire[j]) begin
                enable[j]          = 1'b1;
                select[j]          = pick_idx[j];
                grant[pick_idx[j]] = 1'b1;
            end
            force_rel[j] = locked[j] && credit_ok[j] && !fire[j]
                           && (cnt_q[j] == CNT_W'(LOCK_TIMEOUT - 1));
        end
    end

    // Per-outport lock, owner, pointer and stall-counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked      <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                if (fire[j]) begin
                    cnt_q[j] <= '0;
                    if (req_tail[pick_idx[j]]) begin
                        locked[j] <= 1'b0;
                        ptr_q[j]  <= inc_idx(pick_idx[j]);
                    end else if (!locked[j]) begin
                        locked[j]  <= 1'b1;
                        owner_q[j] <= pick_idx[j];
                    end
                end else if (force_rel[j]) begin
                    locked[j] <= 1'b0;
                    ptr_q[j]  <= inc_idx(owner_q[j]);
                    cnt_q[j]  <= '0;
                end else if (locked[j] && credit_ok[j]) begin
                    cnt_q[j] <= cnt_q[j] + CNT_W'(1);
                end
            end
            if (|force_rel) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_switch_allocator.sv
// Directed self-checking bench for packet_switch_allocator with hand-computed expectations.
module tb_packet_switch_allocator;

    logic            clk;
    logic            rst;
    logic [7:0]      req_valid;
    logic [7:0][1:0] req_outport;
    logic [7:0]      req_tail;
    logic [3:0]      credit_ok;
    logic [7:0]      grant;
    logic [3:0]      enable;
    logic [3:0][2:0] select;
    logic [3:0]      locked;
    logic            timeout_err;

    int unsigned n_chk;
    int unsigned n_fail;

    packet_switch_allocator dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_outport (req_outport),
        .req_tail    (req_tail),
        .credit_ok   (credit_ok),
        .grant       (grant),
        .enable      (enable),
        .select      (select),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        req_tail    = '0;
        req_outport = '0;
        credit_ok   = 4'hf;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle_inputs();
        req_valid = 8'hff;
        req_tail  = 8'hff;

        // Reset with every requester asking for outport 0.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_grant", 32'(grant), 32'h0);
            check("rst_enable", 32'(enable), 32'h0);
            check("rst_select", 32'(select), 32'h0);
        end
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        rst = 1'b0;
        idle_inputs();
        tick();

        // Round-robin among single-flit packets from inputs 1, 3, 5 to outport 2.
        begin
            logic [7:0] exp_order [4];
            exp_order[0] = 8'd1; exp_order[1] = 8'd3; exp_order[2] = 8'd5; exp_order[3] = 8'd1;
            req_valid = 8'b0010_1010;
            req_tail  = 8'hff;
            req_outport[1] = 2'd2; req_outport[3] = 2'd2; req_outport[5] = 2'd2;
            for (int c = 0; c < 4; c++) begin
                #1;
                check("rr_grant", 32'(grant), 32'(8'h1 << exp_order[c]));
                check("rr_select", 32'(select[2]), 32'(exp_order[c]));
                check("rr_enable", 32'(enable), 32'h4);
                tick();
                check("rr_no_lock", 32'(locked), 32'h0);
            end
        end
        idle_inputs();
        tick();

        // Three-flit packet from input 0 on outport 1 holds off input 4.
        req_valid = 8'b0001_0001;
        req_outport[0] = 2'd1; req_outport[4] = 2'd1;
        req_tail[4] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_tail[0] = (c == 2);
            #1;
            check("lock_grant", 32'(grant), 32'h01);
            check("lock_select", 32'(select[1]), 32'h0);
            tick();
            check("lock_locked", 32'(locked[1]), (c == 2) ? 32'h0 : 32'h1);
        end
        req_valid[0] = 1'b0;
        #1;
        check("lock_next_grant", 32'(grant), 32'h10);
        check("lock_next_select", 32'(select[1]), 32'h4);
        tick();
        idle_inputs();
        tick();

        // Independent outports granted in the same cycle.
        req_valid = 8'b0100_0100;
        req_tail  = 8'hff;
        req_outport[2] = 2'd0; req_outport[6] = 2'd3;
        #1;
        check("par_grant", 32'(grant), 32'h44);
        check("par_enable", 32'(enable), 32'h9);
        check("par_select0", 32'(select[0]), 32'h2);
        check("par_select3", 32'(select[3]), 32'h6);
        check("par_select1", 32'(select[1]), 32'h0);
        tick();
        idle_inputs();
        tick();

        // Credit stall on a locked outport must not time out.
        req_valid = 8'h01;
        req_outport[0] = 2'd1;
        #1;
        check("cs_head_grant", 32'(grant), 32'h01);
        tick();
        check("cs_locked", 32'(locked[1]), 32'h1);
        credit_ok[1] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("cs_stall_grant", 32'(grant), 32'h0);
            check("cs_stall_enable", 32'(enable), 32'h0);
            tick();
        end
        check("cs_still_locked", 32'(locked[1]), 32'h1);
        check("cs_no_timeout", 32'(timeout_err), 32'h0);
        credit_ok[1] = 1'b1;
        req_tail[0]  = 1'b1;
        #1;
        check("cs_resume_grant", 32'(grant), 32'h01);
        tick();
        check("cs_unlocked", 32'(locked[1]), 32'h0);
        idle_inputs();
        tick();

        // Owner goes silent for 16 cycles: lock force-released, input 4 wins next.
        req_valid = 8'h01;
        req_outport[0] = 2'd1;
        #1;
        check("to_head_grant", 32'(grant), 32'h01);
        tick();
        check("to_locked", 32'(locked[1]), 32'h1);
        req_valid = 8'h11;
        req_outport[0] = 2'd3;
        req_outport[4] = 2'd1;
        req_tail[4] = 1'b1;
        #1;
        check("to_owner_elsewhere", 32'(grant), 32'h0);
        tick();
        req_valid[0] = 1'b0;
        for (int c = 1; c < 16; c++) begin
            #1;
            check("to_idle_grant", 32'(grant), 32'h0);
            check("to_idle_locked", 32'(locked[1]), 32'h1);
            tick();
        end
        check("to_released", 32'(locked[1]), 32'h0);
        check("to_err", 32'(timeout_err), 32'h1);
        #1;
        check("to_next_grant", 32'(grant), 32'h10);
        check("to_next_select", 32'(select[1]), 32'h4);
        tick();
        idle_inputs();
        tick();
        tick();
        check("to_err_sticky", 32'(timeout_err), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
